// File: rtl/perf_timer_ctrl.sv
// Multi-channel cycle-interval timer sharing one free-running timebase.
// Per-channel one-deep result slots are drained round-robin onto a valid/ready port.
module perf_timer_ctrl #(
  parameter int NCH = 4,
  parameter int CHW = 2,
  parameter int TBW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] start,
  input  logic [NCH-1:0] stop,
  input  logic           clear,
  output logic [NCH-1:0] busy,
  output logic [TBW-1:0] timebase,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [CHW-1:0] res_ch,
  output logic [TBW-1:0] res_cycles,
  output logic           res_ovf
);

  // state | meaning
  // IDLE  | channel not measuring, stop ignored
  // RUN   | interval open, stamp holds its start time
  typedef enum logic {IDLE, RUN} ch_state_t;

  ch_state_t      state [NCH];
  logic [TBW-1:0] stamp [NCH];
  logic [TBW-1:0] sval  [NCH];
  logic [TBW-1:0] elapsed [NCH];
  logic [NCH-1:0] pend;
  logic [NCH-1:0] sovf;
  logic [NCH-1:0] done;
  logic [NCH-1:0] gnt_vec;
  logic           armed;
  logic [CHW-1:0] rr_ptr;
  logic [CHW-1:0] gnt_idx;
  logic           gnt;
  logic           found;
  int             idx;

  // Intervals of 2^TBW cycles or more alias modulo 2^TBW; this is accepted, not flagged.
  always_comb begin
    busy = '0;
    done = '0;
    for (int i = 0; i < NCH; i++) begin
      busy[i]    = (state[i] == RUN);
      done[i]    = (state[i] == RUN) && stop[i] && !clear;
      elapsed[i] = timebase - stamp[i];
    end
  end

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (!found && pend[idx]) begin
        found   = 1'b1;
        gnt_idx = CHW'(idx);
      end
    end
    gnt     = found && (!res_valid || res_ready) && !clear;
    gnt_vec = '0;
    for (int i = 0; i < NCH; i++)
      gnt_vec[i] = gnt && (gnt_idx == CHW'(i));
  end

  // The first cycle out of reset holds zero so downstream sees a full zero cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timebase <= '0;
      armed    <= 1'b0;
    end else if (!armed) begin
      armed <= 1'b1;
    end else begin
      timebase <= timebase + TBW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      sovf <= '0;
      for (int i = 0; i < NCH; i++) begin
        state[i] <= IDLE;
        stamp[i] <= '0;
        sval[i]  <= '0;
      end
    end else if (clear) begin
      pend <= '0;
      sovf <= '0;
      for (int i = 0; i < NCH; i++)
        state[i] <= IDLE;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        case (state[i])
          IDLE: if (start[i]) begin
            state[i] <= RUN;
            stamp[i] <= timebase;
          end
          RUN: begin
            if (start[i])
              stamp[i] <= timebase;
            else if (stop[i])
              state[i] <= IDLE;
          end
          default: state[i] <= IDLE;
        endcase

        // A slot being granted this cycle is free for a new result.
        if (gnt_vec[i]) begin
          sovf[i] <= 1'b0;
          pend[i] <= done[i];
          if (done[i])
            sval[i] <= elapsed[i];
        end else if (done[i]) begin
          if (!pend[i]) begin
            pend[i] <= 1'b1;
            sval[i] <= elapsed[i];
          end else begin
            sovf[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid  <= 1'b0;
      res_ch     <= '0;
      res_cycles <= '0;
      res_ovf    <= 1'b0;
      rr_ptr     <= '0;
    end else if (clear) begin
      res_valid <= 1'b0;
    end else if (gnt) begin
      res_valid  <= 1'b1;
      res_ch     <= gnt_idx;
      res_cycles <= sval[gnt_idx];
      res_ovf    <= sovf[gnt_idx];
      rr_ptr     <= (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_perf_timer_ctrl.sv
// Directed bench for perf_timer_ctrl (TBW=8) with a result scoreboard queue.
module tb_perf_timer_ctrl;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int TBW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] start = '0;
  logic [NCH-1:0] stop = '0;
  logic           clear = 1'b0;
  logic           res_ready = 1'b0;
  logic [NCH-1:0] busy;
  logic [TBW-1:0] timebase;
  logic           res_valid;
  logic [CHW-1:0] res_ch;
  logic [TBW-1:0] res_cycles;
  logic           res_ovf;

  perf_timer_ctrl #(.NCH(NCH), .CHW(CHW), .TBW(TBW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .busy(busy), .timebase(timebase), .res_valid(res_valid),
    .res_ready(res_ready), .res_ch(res_ch), .res_cycles(res_cycles),
    .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [TBW-1:0] cyc;
    logic           ovf;
  } res_t;

  res_t           sbq[$];
  int             n_cmp = 0;
  int             n_bad = 0;
  logic [TBW-1:0] tbm = '0;
  logic           armed_m = 1'b0;
  int             busy0_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input int ch, input int cyc, input logic ovf);
    res_t r;
    r.ch  = CHW'(ch);
    r.cyc = TBW'(cyc);
    r.ovf = ovf;
    sbq.push_back(r);
  endtask

  // Outputs sampled at negedge; inputs change 1 time unit after posedge.
  task automatic tick();
    @(negedge clk);
    check("timebase", 32'(timebase), 32'(tbm));
    if (busy[0]) busy0_cnt++;
    if (res_valid === 1'b1) begin
      if (sbq.size() == 0)
        check("result_unexpected", 32'(res_valid), 32'd0);
      else begin
        check("result", 32'({res_ch, res_cycles, res_ovf}), 32'(sbq[0]));
        if (res_ready) void'(sbq.pop_front());
      end
    end
    @(posedge clk);
    if (rst) begin
      tbm = '0;
      armed_m = 1'b0;
    end else if (!armed_m) armed_m = 1'b1;
    else tbm = tbm + 8'd1;
    #1;
  endtask

  task automatic wait_tb(input logic [TBW-1:0] v);
    int n = 0;
    while (tbm != v && n < 600) begin
      tick();
      n++;
    end
    if (tbm != v) check("wait_tb", 32'(timebase), 32'(v));
  endtask

  task automatic pulse(input logic [NCH-1:0] s, input logic [NCH-1:0] p);
    start = s;
    stop  = p;
    tick();
    start = '0;
    stop  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_timebase"}, 32'(timebase), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_ch"}, 32'(res_ch), 32'd0);
    check({tag, "_res_cycles"}, 32'(res_cycles), 32'd0);
    check({tag, "_res_ovf"}, 32'(res_ovf), 32'd0);
  endtask

  initial begin
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // single interval on ch0: 10 -> 25
    wait_tb(8'd10);
    busy0_cnt = 0;
    pulse(4'b0001, 4'b0000);
    wait_tb(8'd25);
    expect_res(0, 15, 1'b0);
    pulse(4'b0000, 4'b0001);
    check("latency_t1", 32'(res_valid), 32'd0);
    tick();
    check("latency_t2", 32'(res_valid), 32'd1);
    repeat (3) tick();
    check("busy0_cycles", 32'(busy0_cnt), 32'd15);

    // wrap on ch2: 250 -> 4
    wait_tb(8'd250);
    pulse(4'b0100, 4'b0000);
    wait_tb(8'd4);
    expect_res(2, 10, 1'b0);
    pulse(4'b0000, 4'b0100);
    repeat (4) tick();

    // lap and restart on ch3 (leaves round-robin pointer at 0)
    wait_tb(8'd100);
    pulse(4'b1000, 4'b0000);
    wait_tb(8'd120);
    expect_res(3, 20, 1'b0);
    pulse(4'b1000, 4'b1000);
    check("lap_busy3", 32'(busy[3]), 32'd1);
    wait_tb(8'd130);
    expect_res(3, 10, 1'b0);
    pulse(4'b0000, 4'b1000);
    wait_tb(8'd200);
    pulse(4'b1000, 4'b0000);
    wait_tb(8'd205);
    pulse(4'b1000, 4'b0000);
    wait_tb(8'd210);
    expect_res(3, 5, 1'b0);
    pulse(4'b0000, 4'b1000);
    repeat (4) tick();
    check("lap_busy3_end", 32'(busy[3]), 32'd0);

    // simultaneous stops; ch0 laps and its next result must wait behind ch3
    wait_tb(8'd30);
    pulse(4'b1111, 4'b0000);
    wait_tb(8'd40);
    for (int c = 0; c < NCH; c++) expect_res(c, 10, 1'b0);
    start = 4'b0001;
    stop  = 4'b1111;
    tick();
    expect_res(0, 1, 1'b0);
    start = 4'b0000;
    stop  = 4'b0001;
    tick();
    stop = 4'b0000;
    repeat (8) tick();
    check("rr_drained", 32'(sbq.size()), 32'd0);
    check("rr_valid_low", 32'(res_valid), 32'd0);

    // overflow under backpressure on ch1
    res_ready = 1'b0;
    wait_tb(8'd60);
    pulse(4'b0010, 4'b0000);
    wait_tb(8'd65);
    expect_res(1, 5, 1'b0);
    pulse(4'b0000, 4'b0010);
    wait_tb(8'd70);
    pulse(4'b0010, 4'b0000);
    wait_tb(8'd77);
    expect_res(1, 7, 1'b1);
    pulse(4'b0000, 4'b0010);
    wait_tb(8'd80);
    pulse(4'b0010, 4'b0000);
    wait_tb(8'd89);
    pulse(4'b0000, 4'b0010);
    repeat (3) tick();
    check("bp_held_valid", 32'(res_valid), 32'd1);
    check("bp_held_cycles", 32'(res_cycles), 32'd5);
    res_ready = 1'b1;
    repeat (4) tick();
    check("ovf_drained", 32'(sbq.size()), 32'd0);
    check("ovf_valid_low", 32'(res_valid), 32'd0);

    // clear with a result held, a slot pending and ch0 running
    res_ready = 1'b0;
    wait_tb(8'd100);
    pulse(4'b0011, 4'b0000);
    wait_tb(8'd103);
    expect_res(1, 3, 1'b0);
    pulse(4'b0100, 4'b0010);
    wait_tb(8'd106);
    pulse(4'b0000, 4'b0100);
    repeat (2) tick();
    check("pre_clear_valid", 32'(res_valid), 32'd1);
    check("pre_clear_busy0", 32'(busy[0]), 32'd1);
    clear = 1'b1;
    start = 4'b1000;
    tick();
    clear = 1'b0;
    start = 4'b0000;
    sbq.delete();
    check("clear_valid", 32'(res_valid), 32'd0);
    check("clear_busy", 32'(busy), 32'd0);
    res_ready = 1'b1;
    repeat (3) tick();
    check("clear_slots_empty", 32'(res_valid), 32'd0);

    // reset mid-interval
    wait_tb(8'd150);
    pulse(4'b0001, 4'b0000);
    repeat (5) tick();
    check("pre_rst_busy0", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    tbm = '0;
    armed_m = 1'b0;
    sbq.delete();
    #1;
    check_reset_outputs("midrst");
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    check("tb_seq0", 32'(timebase), 32'd0);
    tick();
    check("tb_seq1", 32'(timebase), 32'd0);
    tick();
    check("tb_seq2", 32'(timebase), 32'd1);
    tick();
    check("tb_seq3", 32'(timebase), 32'd2);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/perf_timer_ctrl.md
Name: perf_timer_ctrl

Overview:
- Multi-channel cycle-measurement controller built around one shared free-running timebase counter.
- Up to NCH requesters (datapath stages, test sequencers) issue start/stop pulses. The block timestamps each interval and computes elapsed cycles.
- Completed measurements from all channels are arbitrated round-robin onto one valid/ready result port read by the host/logger.

Parameters:
- NCH, 4, number of measurement channels (2..16)
- CHW, 2, width of channel index, ceil(log2(NCH))
- TBW, 32, timebase and result width in bits

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  NCH  per-channel start pulse, 1 cycle
- stop  in  NCH  per-channel stop pulse, 1 cycle
- clear  in  1  synchronous soft clear of channel/result state
- busy  out  NCH  channel is in RUN
- timebase  out  TBW  current timebase value
- res_valid  out  1  result register holds a result
- res_ready  in  1  consumer accepts result
- res_ch  out  CHW  channel that produced the result
- res_cycles  out  TBW  elapsed cycles
- res_ovf  out  1  at least one later result from this channel was dropped before this one was delivered

Behaviour:
- Reset: timebase=0, arm flag=0, all channels IDLE, busy=0, all slots empty, ovf flags=0, res_valid=0, res_ch=0, res_cycles=0, res_ovf=0, RR pointer=0.
- Timebase: first cycle after reset holds 0 and sets the arm flag. Afterwards it increments by 1 every cycle and wraps 2^TBW-1 -> 0. It is not affected by clear.
- Channel FSM, states IDLE/RUN, independent per channel:
  - IDLE & start: -> RUN, stamp<=timebase. Stop in IDLE is ignored.
  - RUN & stop & !start: -> IDLE, result=timebase-stamp mod 2^TBW, written to slot.
  - RUN & stop & start (lap): result produced as above, stamp<=timebase, stays RUN.
  - RUN & start & !stop: restart, stamp<=timebase, no result.
- busy[i]=1 in RUN (registered).
- Elapsed arithmetic is unsigned modulo 2^TBW, so wrap is handled. Intervals >= 2^TBW cycles alias and this is documented, not flagged.
- Result slot per channel is one deep: pending bit + value + ovf bit.
  - New result with slot empty, or slot granted to output the same cycle: stored, pending=1.
  - New result with slot pending and not granted: the new result is discarded and ovf is set sticky.
  - Slot's ovf is transferred to res_ovf on grant, then cleared.
- Output arbiter:
  - Grant occurs when (!res_valid | res_ready) and any slot is pending.
  - Round-robin: search starts at RR pointer; after a grant, pointer = granted+1 mod NCH.
  - Granted slot loads the output register (res_ch/res_cycles/res_ovf), res_valid=1, slot pending=0.
  - With no grant and res_ready=1, res_valid<=0.
- Throughput: one result per cycle with res_ready held high.
- Latency: stop sampled at cycle T -> slot pending at T+1 -> res_valid earliest at T+2.
- Backpressure: while res_valid & !res_ready, all res_* outputs hold stable.
- Clear: next edge sets all channels IDLE, slots empty, ovf=0, res_valid=0. start/stop in the clear cycle are ignored.
- Reset mid-operation: immediate return to reset values. In-flight intervals and results are lost.

Test Plan:
- Single interval: start[0] when timebase=10, stop[0] when timebase=25, res_ready=1 -> two cycles later res_valid=1, res_ch=0, res_cycles=15, res_ovf=0; busy[0] high for exactly 15 cycles.
- Wrap (TBW=8): start[2] at timebase=250, stop[2] at timebase=4 -> res_cycles=10, res_ch=2.
- Simultaneous stops: all 4 channels running, stop=4'b1111 in one cycle, res_ready=1, pointer=0 -> results ch0,ch1,ch2,ch3 on consecutive cycles. A following single ch0 result is granted only after ch3 (pointer=0 again).
- Overflow/backpressure: res_ready=0 from the outset, no result in output register; ch1 intervals of 5 then 7 cycles -> first result (5) sits in output register, stable. Second result (7) goes to the empty ch1 slot. A third interval (9) is dropped and sets ovf. Release ready -> 5 with ovf=0, then 7 with ovf=1, no third result.
- Lap and restart:
  - ch3 start at 100, start+stop at 120, stop at 130 -> results 20 then 10.
  - start at 200, start at 205, stop at 210 -> single result 5.
- Clear and reset: results pending with ch0 in RUN, assert clear -> res_valid=0, busy=0, timebase continues. Repeat with rst mid-interval -> all outputs to reset values, timebase restarts 0,0,1,2.
